// File: rtl/hand_pkg.sv
// hand_pkg: shared card type, seven-segment glyphs and card scoring helpers
// for the baccarat hand display. Segments are active-low, bit order {g,f,e,d,c,b,a}.
package hand_pkg;

    typedef logic [3:0] card_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ACE   = 7'b0001000;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_10    = 7'b1000000;
    localparam logic [6:0] SEG_JACK  = 7'b1100001;
    localparam logic [6:0] SEG_QUEEN = 7'b0011000;
    localparam logic [6:0] SEG_KING  = 7'b0001001;

    // Baccarat value: pip cards count face value, tens and court cards count zero.
    function automatic logic [3:0] card_val(input card_t c);
        return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
    endfunction

    // Only A..K (1..13) are real cards; 0, 14 and 15 are rejected.
    function automatic logic card_legal(input card_t c);
        return (c != 4'd0) && (c <= 4'd13);
    endfunction

endpackage

// File: rtl/card_seg_enc.sv
// card_seg_enc: combinational card code to active-low seven-segment glyph.
// Code 0 (empty slot) and illegal codes show blank.
module card_seg_enc
    import hand_pkg::*;
(
    input  card_t      card_i,
    output logic [6:0] seg_o
);

    // Glyph lookup, blank by default.
    always_comb begin
        seg_o = SEG_BLANK;
        case (card_i)
            4'd1:    seg_o = SEG_ACE;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            4'd10:   seg_o = SEG_10;
            4'd11:   seg_o = SEG_JACK;
            4'd12:   seg_o = SEG_QUEEN;
            4'd13:   seg_o = SEG_KING;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hand_display.sv
// hand_display: registered card slots, running baccarat score and per-slot
// seven-segment digits for one hand. Optional last-card blink is built when
// the macro HAND_BLINK_EN is defined.
module hand_display
    import hand_pkg::*;
#(
    parameter int NUM_SLOTS  = 3,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic                               slow_clock,
    input  logic                               resetb,
    input  logic                               clear,
    input  logic                               card_valid,
    input  card_t                              card,
    output logic                               card_ready,
    output logic                               card_err,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     count,
    output logic                               full,
    output logic [3:0]                         score,
    output logic [NUM_SLOTS-1:0][6:0]          HEX
);

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    if (NUM_SLOTS < 1 || NUM_SLOTS > 6) begin : g_bad_slots
        $error("hand_display: NUM_SLOTS must be in 1..6");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("hand_display: BLINK_HALF must be at least 1");
    end

    card_t [NUM_SLOTS-1:0]     slot_q, slot_d;
    logic  [CNT_W-1:0]         count_q, count_d;
    logic  [3:0]               score_q, score_d;
    logic                      err_q, err_d;
    logic  [NUM_SLOTS-1:0][6:0] hex_q, hex_d;
    logic  [NUM_SLOTS-1:0][6:0] glyph;
    logic  [4:0]               sum;
    logic                      accept;

`ifdef HAND_BLINK_EN
    localparam int BCW = $clog2(BLINK_HALF + 1);
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic             blank_q, blank_d;
    logic             blink_on_q, blink_on_d;
    logic [CNT_W-1:0] last_q, last_d;
`endif

    assign full       = (count_q == CNT_W'(NUM_SLOTS));
    assign card_ready = !full;
    assign accept     = card_valid && card_ready && card_legal(card) && !clear;

    // Each digit shows what its slot will hold after this edge, so HEX lands with count/score.
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_enc
        card_seg_enc u_enc (
            .card_i (slot_d[g]),
            .seg_o  (glyph[g])
        );
    end

    // Next-state for slots, occupancy, score, error pulse and digit registers.
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        score_d = score_q;
        err_d   = 1'b0;
        sum     = {1'b0, score_q} + {1'b0, card_val(card)};
`ifdef HAND_BLINK_EN
        bcnt_d     = bcnt_q;
        blank_d    = blank_q;
        blink_on_d = blink_on_q;
        last_d     = last_q;
        if (blink_on_q) begin
            if (bcnt_q == BCW'(BLINK_HALF - 1)) begin
                bcnt_d  = '0;
                blank_d = !blank_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
`endif
        if (clear) begin
            // Clear beats any card offered in the same cycle; that card is dropped silently.
            slot_d  = '0;
            count_d = '0;
            score_d = '0;
`ifdef HAND_BLINK_EN
            blink_on_d = 1'b0;
            blank_d    = 1'b0;
            bcnt_d     = '0;
`endif
        end else if (accept) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (count_q == CNT_W'(i)) begin
                    slot_d[i] = card;
                end
            end
            count_d = count_q + 1'b1;
            score_d = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
`ifdef HAND_BLINK_EN
            last_d     = count_q;
            blink_on_d = 1'b1;
            blank_d    = 1'b0;
            bcnt_d     = '0;
`endif
        end else if (card_valid && card_ready) begin
            err_d = 1'b1;
        end

        hex_d = glyph;
`ifdef HAND_BLINK_EN
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (blink_on_d && blank_d && last_d == CNT_W'(i)) begin
                hex_d[i] = SEG_BLANK;
            end
        end
`endif
    end

    // State registers; reset blanks the display and empties the hand at once.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            slot_q  <= '0;
            count_q <= '0;
            score_q <= '0;
            err_q   <= 1'b0;
            hex_q   <= {NUM_SLOTS{SEG_BLANK}};
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
            score_q <= score_d;
            err_q   <= err_d;
            hex_q   <= hex_d;
        end
    end

`ifdef HAND_BLINK_EN
    // Blink timer for the most recently accepted slot.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            bcnt_q     <= '0;
            blank_q    <= 1'b0;
            blink_on_q <= 1'b0;
            last_q     <= '0;
        end else begin
            bcnt_q     <= bcnt_d;
            blank_q    <= blank_d;
            blink_on_q <= blink_on_d;
            last_q     <= last_d;
        end
    end
`endif

    assign count    = count_q;
    assign score    = score_q;
    assign card_err = err_q;
    assign HEX      = hex_q;

endmodule

// File: tb/tb_hand_display.sv
// tb_hand_display: directed stimulus for hand_display with a behavioural hand
// model checked every cycle, plus literal expectations from the test plan.
// Blink checks are compiled when HAND_BLINK_EN is defined.
module tb_hand_display;

    localparam int NS = 3;
    localparam int BH = 4;

    logic            slow_clock = 1'b0;
    logic            resetb     = 1'b0;
    logic            clear      = 1'b0;
    logic            card_valid = 1'b0;
    logic [3:0]      card       = 4'd0;
    logic            card_ready;
    logic            card_err;
    logic [1:0]      count;
    logic            full;
    logic [3:0]      score;
    logic [NS-1:0][6:0] HEX;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    hand_display #(.NUM_SLOTS(NS), .BLINK_HALF(BH)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clear      (clear),
        .card_valid (card_valid),
        .card       (card),
        .card_ready (card_ready),
        .card_err   (card_err),
        .count      (count),
        .full       (full),
        .score      (score),
        .HEX        (HEX)
    );

    always #5 slow_clock = ~slow_clock;

    // Behavioural hand: list of cards, score as plain mod-10 sum, age since last accept.
    int m_cards [NS];
    int m_count = 0;
    int m_score = 0;
    bit m_err   = 0;
    bit m_blink = 0;
    int m_last  = 0;
    int m_age   = 0;

    function automatic logic [6:0] m_glyph(int c);
        case (c)
            1:  return 7'b0001000;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b1000000;
            11: return 7'b1100001;
            12: return 7'b0011000;
            13: return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] m_hex(int i);
        logic [6:0] g;
        g = (i < m_count) ? m_glyph(m_cards[i]) : 7'b1111111;
`ifdef HAND_BLINK_EN
        if (m_blink && i == m_last && ((m_age / BH) % 2) == 1) g = 7'b1111111;
`endif
        return g;
    endfunction

    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NS; i++) m_cards[i] = 0;
            m_count = 0; m_score = 0; m_err = 0; m_blink = 0; m_age = 0; m_last = 0;
        end else begin
            m_err = 0;
            m_age = m_age + 1;
            if (clear) begin
                for (int i = 0; i < NS; i++) m_cards[i] = 0;
                m_count = 0; m_score = 0; m_blink = 0;
            end else if (card_valid && m_count < NS) begin
                if (int'(card) >= 1 && int'(card) <= 13) begin
                    m_cards[m_count] = int'(card);
                    m_last  = m_count;
                    m_count = m_count + 1;
                    m_score = (m_score + (card < 10 ? int'(card) : 0)) % 10;
                    m_age   = 0;
                    m_blink = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge slow_clock) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(m_count));
            chk("score", 32'(score), 32'(m_score));
            chk("card_err", 32'(card_err), 32'(m_err));
            chk("card_ready", 32'(card_ready), 32'(m_count < NS));
            chk("full", 32'(full), 32'(m_count == NS));
            for (int i = 0; i < NS; i++) chk($sformatf("HEX[%0d]", i), 32'(HEX[i]), 32'(m_hex(i)));
        end
    end

    task automatic apply(input bit v, input int c, input bit cl);
        card_valid = v;
        card       = 4'(c);
        clear      = cl;
        @(posedge slow_clock);
        #1;
        card_valid = 1'b0;
        card       = 4'd0;
        clear      = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge slow_clock);
        #1;
        chk("rst HEX", 32'(HEX), 32'(21'h1FFFFF));
        chk("rst count", 32'(count), 32'd0);
        chk("rst score", 32'(score), 32'd0);
        chk("rst card_ready", 32'(card_ready), 32'd1);
        chk("rst card_err", 32'(card_err), 32'd0);
        resetb = 1'b1;
        chk_en = 1'b1;

        // 7 then 8: score 15 mod 10 = 5
        apply(1, 7, 0);
        apply(1, 8, 0);
        chk("lit HEX0 seven", 32'(HEX[0]), 32'(7'b1111000));
        chk("lit HEX1 eight", 32'(HEX[1]), 32'(7'b0000000));
        chk("lit score 7+8", 32'(score), 32'd5);
        chk("lit count 2", 32'(count), 32'd2);

        // K, 9, Q from empty: score 9, full
        apply(0, 0, 1);
        apply(1, 13, 0);
        apply(1, 9, 0);
        apply(1, 12, 0);
        chk("lit score KQ9", 32'(score), 32'd9);
        chk("lit full", 32'(full), 32'd1);
        chk("lit ready full", 32'(card_ready), 32'd0);
        apply(1, 3, 0);
        chk("lit count hold", 32'(count), 32'd3);
        chk("lit no err full", 32'(card_err), 32'd0);
        chk("lit HEX2 queen", 32'(HEX[2]), 32'(7'b0011000));

        // illegal codes on an empty hand
        apply(0, 0, 1);
        apply(1, 0, 0);
        chk("lit err code0", 32'(card_err), 32'd1);
        apply(0, 0, 0);
        chk("lit err drop", 32'(card_err), 32'd0);
        apply(1, 15, 0);
        chk("lit err code15", 32'(card_err), 32'd1);
        chk("lit count illegal", 32'(count), 32'd0);
        apply(1, 14, 0);
        apply(1, 10, 0);
        chk("lit HEX0 ten", 32'(HEX[0]), 32'(7'b1000000));
        apply(1, 11, 0);
        chk("lit HEX1 jack", 32'(HEX[1]), 32'(7'b1100001));

        // clear wins over a same-cycle card
        apply(1, 1, 0);
        apply(1, 5, 1);
        chk("lit clr HEX", 32'(HEX), 32'(21'h1FFFFF));
        chk("lit clr count", 32'(count), 32'd0);
        chk("lit clr score", 32'(score), 32'd0);
        chk("lit clr err", 32'(card_err), 32'd0);
        apply(1, 5, 0);
        chk("lit HEX0 five", 32'(HEX[0]), 32'(7'b0010010));

        // asynchronous reset in the middle of a cycle
        apply(1, 4, 0);
        #3;
        resetb = 1'b0;
        #1;
        chk("lit async HEX", 32'(HEX), 32'(21'h1FFFFF));
        chk("lit async count", 32'(count), 32'd0);
        chk("lit async score", 32'(score), 32'd0);
        @(posedge slow_clock);
        #1;
        resetb = 1'b1;

`ifdef HAND_BLINK_EN
        apply(1, 1, 0);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("lit blink k%0d", k), 32'(HEX[0]),
                32'(((k / BH) % 2 == 1) ? 7'b1111111 : 7'b0001000));
            @(posedge slow_clock);
            #1;
        end
        apply(1, 2, 0);
        for (int k = 0; k < 10; k++) begin
            chk("lit steady HEX0", 32'(HEX[0]), 32'(7'b0001000));
            @(posedge slow_clock);
            #1;
        end
        #2;
        resetb = 1'b0;
        #1;
        chk("lit blink rst HEX", 32'(HEX), 32'(21'h1FFFFF));
        @(posedge slow_clock);
        #1;
        resetb = 1'b1;
`endif

        repeat (3) @(posedge slow_clock);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hand_display.md
# hand_display

Registered, parametrised display and scoring block for one baccarat hand. It accepts cards one at a time over a valid/ready handshake and stores up to NUM_SLOTS cards. Each stored card drives its own seven-segment digit, and the block keeps a running hand score (sum mod 10). It sits between the game datapath and the HEX digits, replacing the per-digit combinational card decoders.

## Interface
- NUM_SLOTS, 3: number of card slots and HEX digits; legal range 1..6.
- BLINK_HALF, 25_000_000: half-period of the last-card blink, in clock cycles; ≥1; used only with HAND_BLINK_EN.

- slow_clock  in  1  sole clock; every register updates on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; empties the hand.
- card_valid  in  1  a card is presented this cycle.
- card  in  4  card code: 1=A, 2..10 pip, 11=J, 12=Q, 13=K.
- card_ready  out  1  hand can take a card; equals !full.
- card_err  out  1  one-cycle pulse when an illegal code is presented.
- count  out  $clog2(NUM_SLOTS+1)  number of cards held.
- full  out  1  count == NUM_SLOTS.
- score  out  4  hand score, 0..9.
- HEX  out  NUM_SLOTS×7  active-low segments; slot i drives HEX[i].

## Operation
- Reset values:
  - slots all 0; HEX all 7'b1111111; count 0; full 0; score 0.
  - card_ready 1; card_err 0.
- Accept occurs when card_valid && card_ready && card is in 1..13:
  - card is written to slot[count];
  - count increments by 1;
  - score becomes (score + val(card)) mod 10.
- val(card) is card for 1..9 and 0 for 10..13.
- Illegal code (0, 14, 15) with card_valid && card_ready:
  - no state change;
  - card_err pulses high on the next cycle.
- card_valid while full: ignored; no error; the producer holds the card.
- Occupancy states:
  - EMPTY: count 0.
  - PARTIAL: 0 < count < NUM_SLOTS.
  - FULL: count == NUM_SLOTS.
  - Transitions come only from an accept or from clear; there is no wrap-around.
- clear returns to EMPTY: slots 0, count 0, score 0.
- clear wins over an accept presented in the same cycle; that card is dropped and card_err stays 0.
- Digit encoding:
  - empty slot (code 0) shows blank;
  - A, 2..9 show the corresponding glyph; 10 shows 7'b1000000; J, Q, K show their glyphs.
  - Glyphs are identical to the existing single-digit card decoder.

## Timing
- All outputs are registered, except card_ready and full, which are combinational from count.
- Latency from accept edge N: HEX[slot], count and score change at edge N+1. There is exactly one cycle of latency.
- At most one card is accepted per cycle.
- card_ready rises in the cycle after a clear is sampled.
- Reset mid-operation forces all reset values immediately (asynchronously) and discards any in-flight handshake.

## Configuration
- HAND_BLINK_EN defined:
  - the most recently accepted slot blinks;
  - the digit is visible for BLINK_HALF cycles, then blank for BLINK_HALF cycles, repeating;
  - the blink counter restarts in the visible phase on every accept;
  - clear or reset stops blinking;
  - other slots are steady.
- HAND_BLINK_EN undefined: no blink counter exists; all occupied digits are steady.

## Structure
- hand_pkg contains:
  - the card_t typedef (logic [3:0]);
  - the segment glyph constants, including BLANK;
  - the card_val function (card_t to 0..9).
- One sub-module, card_seg_enc: combinational card_t to 7-bit active-low glyph, instantiated NUM_SLOTS times in a generate loop.
- Top level: slot registers, count, score, error flag, and the optional blink counter.

## Test plan
- Reset → HEX all 7'h7F, count 0, score 0, card_ready 1.
- Accept 7, then 8 (NUM_SLOTS=3) → HEX[0]=7'b1111000, HEX[1]=7'b0000000, score 5, count 2.
- Accept K, 9, Q → score 9, full 1, card_ready 0; a fourth card_valid with 3 → no change, card_err stays 0.
- card=0, then card=15, with card_valid → card_err pulses once per presentation; count unchanged.
- Full hand, then clear and card_valid=1 with card 5 in the same cycle → all HEX blank, count 0, score 0, card_err 0; accepting 5 next cycle → HEX[0]=7'b0010010.
- HAND_BLINK_EN with BLINK_HALF=4, accept A → HEX[0] shows 7'b0001000 for 4 cycles, blank for 4, repeating; accept 2 → HEX[0] steady and HEX[1] blinks; resetb low mid-blink → all blank at once.
